// File: rtl/vga_timing_gen.sv
// vga_timing_gen: parametrised VGA raster timing generator.
//   A system-clock divider produces the pixel rate. Horizontal and vertical
//   counters scan the raster with programmable porch/sync/active widths.
//   Every output is registered.
// Ports:
//   clk, rst     system clock, async active-high reset
//   en           run enable; low freezes divider and counters
//   pix_tick     one-clk pulse per pixel period (registered divider tick)
//   hsync/vsync  sync outputs, active level HS_POL / VS_POL
//   video_on     high inside the visible region
//   pixel_x/y    current raster coordinate
//   line_start   one-clk strobe with the first pixel_x==0 of each line
//   frame_start  one-clk strobe with the first (0,0) of each frame
module vga_timing_gen #(
  parameter int   CLK_DIV  = 4,
  parameter int   H_ACTIVE = 640,
  parameter int   H_FP     = 16,
  parameter int   H_SYNC   = 96,
  parameter int   H_BP     = 48,
  parameter int   V_ACTIVE = 480,
  parameter int   V_FP     = 10,
  parameter int   V_SYNC   = 2,
  parameter int   V_BP     = 33,
  parameter logic HS_POL   = 1'b0,
  parameter logic VS_POL   = 1'b0,
  parameter int   CW       = 10
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  output logic          pix_tick,
  output logic          hsync,
  output logic          vsync,
  output logic          video_on,
  output logic [CW-1:0] pixel_x,
  output logic [CW-1:0] pixel_y,
  output logic          line_start,
  output logic          frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int DW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [CW-1:0] H_LAST   = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_LAST   = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] H_ACT    = CW'(H_ACTIVE);
  localparam logic [CW-1:0] V_ACT    = CW'(V_ACTIVE);
  localparam logic [CW-1:0] HS_BEG   = CW'(H_ACTIVE + H_FP);
  localparam logic [CW-1:0] HS_END   = CW'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [CW-1:0] VS_BEG   = CW'(V_ACTIVE + V_FP);
  localparam logic [CW-1:0] VS_END   = CW'(V_ACTIVE + V_FP + V_SYNC - 1);

  generate
    if (CLK_DIV < 1 || H_ACTIVE < 1 || H_FP < 1 || H_SYNC < 1 || H_BP < 1 ||
        V_ACTIVE < 1 || V_FP < 1 || V_SYNC < 1 || V_BP < 1 ||
        H_TOTAL > (1 << CW) || V_TOTAL > (1 << CW)) begin : g_bad_params
      $error("vga_timing_gen: unsupported parameter set");
    end
  endgenerate

  logic [DW-1:0] div;
  logic [CW-1:0] h_cnt, v_cnt;
  logic          tick_int, h_last, v_last;
  logic          line_wrap_q, frame_wrap_q;

  // With CLK_DIV=1 div is pinned at 0, so tick_int simply follows en.
  assign tick_int = en && (div == DIV_LAST);
  assign h_last   = (h_cnt == H_LAST);
  assign v_last   = (v_cnt == V_LAST);

  // Divider and raster counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div   <= '0;
      h_cnt <= '0;
      v_cnt <= '0;
    end else begin
      if (en) div <= tick_int ? '0 : div + 1'b1;
      if (tick_int) begin
        if (h_last) begin
          h_cnt <= '0;
          v_cnt <= v_last ? '0 : v_cnt + 1'b1;
        end else begin
          h_cnt <= h_cnt + 1'b1;
        end
      end
    end
  end

  // The wrap flags are captured as the counters wrap and delivered one clk
  // later, alongside the output register that first shows coordinate 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      line_wrap_q  <= 1'b0;
      frame_wrap_q <= 1'b0;
    end else begin
      line_wrap_q  <= tick_int && h_last;
      frame_wrap_q <= tick_int && h_last && v_last;
    end
  end

  // Output register: decodes the counters every clk.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pix_tick    <= 1'b0;
      pixel_x     <= '0;
      pixel_y     <= '0;
      video_on    <= 1'b0;
      hsync       <= ~HS_POL;
      vsync       <= ~VS_POL;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      pix_tick    <= tick_int;
      pixel_x     <= h_cnt;
      pixel_y     <= v_cnt;
      video_on    <= (h_cnt < H_ACT) && (v_cnt < V_ACT);
      hsync       <= (h_cnt >= HS_BEG && h_cnt <= HS_END) ? HS_POL : ~HS_POL;
      vsync       <= (v_cnt >= VS_BEG && v_cnt <= VS_END) ? VS_POL : ~VS_POL;
      line_start  <= line_wrap_q;
      frame_start <= frame_wrap_q;
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen. Instance A uses the default 640x480
// timing; instance B uses a tiny raster (CLK_DIV=1, HS_POL=1, 15x7) so that
// whole frames fit in a short run. Expected outputs come from a closed-form
// model of the raster position versus the number of enabled clocks.
module tb_vga_timing_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a, en_a, rst_b, en_b;
  logic a_tick, a_hs, a_vs, a_vid, a_ls, a_fs;
  logic b_tick, b_hs, b_vs, b_vid, b_ls, b_fs;
  logic [9:0] a_x, a_y, b_x, b_y;

  vga_timing_gen dut_a (
    .clk(clk), .rst(rst_a), .en(en_a), .pix_tick(a_tick), .hsync(a_hs),
    .vsync(a_vs), .video_on(a_vid), .pixel_x(a_x), .pixel_y(a_y),
    .line_start(a_ls), .frame_start(a_fs)
  );

  vga_timing_gen #(
    .CLK_DIV(1), .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .HS_POL(1'b1), .VS_POL(1'b1), .CW(10)
  ) dut_b (
    .clk(clk), .rst(rst_b), .en(en_b), .pix_tick(b_tick), .hsync(b_hs),
    .vsync(b_vs), .video_on(b_vid), .pixel_x(b_x), .pixel_y(b_y),
    .line_start(b_ls), .frame_start(b_fs)
  );

  int n_cmp = 0;
  int n_err = 0;

  // model state: enabled-edge count since reset release, last-edge tick
  int ma, mb;
  bit pta, ptb;
  int ex, ey;
  bit evid, ehin, evin, etick, els, efs;
  logic [25:0] act, exp_v;

  task automatic model(input int m, input int cd, input int ht, input int vt,
                       input int ha, input int hs0, input int hs1,
                       input int va, input int vs0, input int vs1,
                       output int x, output int y, output bit vid,
                       output bit hin, output bit vin);
    int p;
    p   = m / cd;
    x   = p % ht;
    y   = (p / ht) % vt;
    vid = (x < ha) && (y < va);
    hin = (x >= hs0) && (x <= hs1);
    vin = (y >= vs0) && (y <= vs1);
  endtask

  // One clk on A: drive en, sample at the falling edge, produce expectations.
  task automatic step_a(input bit e);
    en_a = e;
    @(posedge clk);
    @(negedge clk);
    model(ma, 4, 800, 525, 640, 656, 751, 480, 490, 491, ex, ey, evid, ehin, evin);
    etick = e && (ma % 4 == 3);
    els   = pta && (ex == 0);
    efs   = els && (ey == 0);
    ma    = ma + int'(e);
    pta   = etick;
    act   = {a_x, a_y, a_vid, a_hs, a_vs, a_tick, a_ls, a_fs};
    exp_v = {10'(ex), 10'(ey), evid, ~ehin, ~evin, etick, els, efs};
  endtask

  task automatic step_b(input bit e);
    en_b = e;
    @(posedge clk);
    @(negedge clk);
    model(mb, 1, 15, 7, 8, 10, 12, 4, 5, 5, ex, ey, evid, ehin, evin);
    etick = e;
    els   = ptb && (ex == 0);
    efs   = els && (ey == 0);
    mb    = mb + int'(e);
    ptb   = etick;
    act   = {b_x, b_y, b_vid, b_hs, b_vs, b_tick, b_ls, b_fs};
    exp_v = {10'(ex), 10'(ey), evid, ehin, evin, etick, els, efs};
  endtask

  task automatic test_reset();
    rst_a = 1'b1; rst_b = 1'b1; en_a = 1'b1; en_b = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({a_x, a_y, a_vid, a_hs, a_vs, a_tick, a_ls, a_fs} !== {20'd0, 1'b0, 1'b1, 1'b1, 3'b000}) begin
      n_err++;
      $display("FAIL reset_a: got %h want %h", {a_x, a_y, a_vid, a_hs, a_vs, a_tick, a_ls, a_fs},
               {20'd0, 1'b0, 1'b1, 1'b1, 3'b000});
    end
    n_cmp++;
    if ({b_x, b_y, b_vid, b_hs, b_vs, b_tick, b_ls, b_fs} !== 26'd0) begin
      n_err++;
      $display("FAIL reset_b: got %h want %h", {b_x, b_y, b_vid, b_hs, b_vs, b_tick, b_ls, b_fs}, 26'd0);
    end
    rst_a = 1'b0; ma = 0; pta = 1'b0;
    step_a(1'b1);
    n_cmp++;
    if ({a_x, a_y, a_vid, a_tick, a_ls, a_fs} !== {20'd0, 1'b1, 3'b000}) begin
      n_err++;
      $display("FAIL first_pixel: got x=%0d y=%0d vid=%b tick=%b want 0 0 1 0", a_x, a_y, a_vid, a_tick);
    end
  endtask

  task automatic test_line_a();
    int hs_low, n_ls, n_tick, ls_at0, ls_at1;
    hs_low = 0; n_ls = 0; n_tick = 0; ls_at0 = 0; ls_at1 = 0;
    for (int k = 2; k <= 6501; k++) begin
      step_a(1'b1);
      n_cmp++;
      if (act !== exp_v) begin
        n_err++;
        $display("FAIL line_a k=%0d: got %h want %h", k, act, exp_v);
      end
      if (a_y == 10'd0 && a_hs == 1'b0) hs_low++;
      if (a_tick) n_tick++;
      if (a_ls) begin
        n_ls++;
        if (n_ls == 1) ls_at0 = k;
        if (n_ls == 2) ls_at1 = k;
      end
    end
    n_cmp++;
    if (hs_low != 384) begin n_err++; $display("FAIL hsync_width: got %0d clks want 384", hs_low); end
    n_cmp++;
    if (n_tick != 1625) begin n_err++; $display("FAIL tick_count: got %0d want 1625", n_tick); end
    n_cmp++;
    if (n_ls != 2 || ls_at0 != 3201) begin
      n_err++; $display("FAIL line_start_pos: got n=%0d at=%0d want 2 at 3201", n_ls, ls_at0);
    end
    n_cmp++;
    if (ls_at1 - ls_at0 != 3200) begin
      n_err++; $display("FAIL line_period: got %0d want 3200", ls_at1 - ls_at0);
    end
  endtask

  task automatic test_en_freeze_a();
    int n;
    n = 0;
    do begin
      step_a(1'b1);
      n++;
      n_cmp++;
      if (act !== exp_v) begin n_err++; $display("FAIL pre_freeze: got %h want %h", act, exp_v); end
    end while (a_x != 10'd300 && n < 2000);
    n_cmp++;
    if (a_x !== 10'd300) begin n_err++; $display("FAIL reach_300: got x=%0d want 300", a_x); end
    for (int i = 0; i < 37; i++) begin
      step_a(1'b0);
      n_cmp++;
      if (act !== exp_v || a_x !== 10'd300 || a_tick || a_ls || a_fs) begin
        n_err++; $display("FAIL freeze i=%0d: got %h want %h", i, act, exp_v);
      end
    end
    n = 0;
    do begin
      step_a(1'b1);
      n++;
      n_cmp++;
      if (act !== exp_v) begin n_err++; $display("FAIL resume: got %h want %h", act, exp_v); end
    end while (a_x != 10'd301 && n < 20);
    n_cmp++;
    if (n != 4) begin n_err++; $display("FAIL resume_latency: got %0d clks want 4", n); end
    for (int i = 0; i < 20; i++) begin
      step_a(1'b1);
      n_cmp++;
      if (act !== exp_v) begin n_err++; $display("FAIL post_resume: got %h want %h", act, exp_v); end
    end
  endtask

  task automatic test_reset_mid_a();
    int n;
    n = 0;
    do begin
      step_a(1'b1);
      n++;
      n_cmp++;
      if (act !== exp_v) begin n_err++; $display("FAIL to_700: got %h want %h", act, exp_v); end
    end while (a_x != 10'd700 && n < 4000);
    n_cmp++;
    if (a_x !== 10'd700 || a_hs !== 1'b0) begin
      n_err++; $display("FAIL at_700: got x=%0d hs=%b want 700 0", a_x, a_hs);
    end
    #2 rst_a = 1'b1;
    #1;
    n_cmp++;
    if ({a_x, a_y, a_vid, a_hs, a_vs, a_tick, a_ls, a_fs} !== {20'd0, 1'b0, 1'b1, 1'b1, 3'b000}) begin
      n_err++;
      $display("FAIL async_reset: got %h want %h", {a_x, a_y, a_vid, a_hs, a_vs, a_tick, a_ls, a_fs},
               {20'd0, 1'b0, 1'b1, 1'b1, 3'b000});
    end
    repeat (2) @(negedge clk);
    rst_a = 1'b0; ma = 0; pta = 1'b0;
    for (int i = 0; i < 40; i++) begin
      step_a(1'b1);
      n_cmp++;
      if (act !== exp_v) begin n_err++; $display("FAIL restart i=%0d: got %h want %h", i, act, exp_v); end
    end
  endtask

  task automatic test_frame_b();
    int n_fs, n_ls, n_tick, hs_hi, vs_hi, vid_on, fs_at0, fs_at1;
    n_fs = 0; n_ls = 0; n_tick = 0; hs_hi = 0; vs_hi = 0; vid_on = 0; fs_at0 = 0; fs_at1 = 0;
    rst_b = 1'b0; mb = 0; ptb = 1'b0;
    for (int k = 1; k <= 250; k++) begin
      step_b(1'b1);
      n_cmp++;
      if (act !== exp_v) begin n_err++; $display("FAIL frame_b k=%0d: got %h want %h", k, act, exp_v); end
      if (b_tick) n_tick++;
      if (b_ls) n_ls++;
      if (k <= 105) begin
        if (b_hs) hs_hi++;
        if (b_vs) vs_hi++;
        if (b_vid) vid_on++;
      end
      if (b_fs) begin
        n_fs++;
        if (n_fs == 1) fs_at0 = k;
        if (n_fs == 2) fs_at1 = k;
        n_cmp++;
        if (!b_ls || b_x !== 10'd0 || b_y !== 10'd0) begin
          n_err++; $display("FAIL fs_align: got ls=%b x=%0d y=%0d want 1 0 0", b_ls, b_x, b_y);
        end
      end
    end
    n_cmp++;
    if (n_tick != 250) begin n_err++; $display("FAIL tick_const: got %0d want 250", n_tick); end
    n_cmp++;
    if (hs_hi != 21) begin n_err++; $display("FAIL hsync_b: got %0d want 21", hs_hi); end
    n_cmp++;
    if (vs_hi != 15) begin n_err++; $display("FAIL vsync_b: got %0d want 15", vs_hi); end
    n_cmp++;
    if (vid_on != 32) begin n_err++; $display("FAIL video_b: got %0d want 32", vid_on); end
    n_cmp++;
    if (n_ls != 16) begin n_err++; $display("FAIL line_count_b: got %0d want 16", n_ls); end
    n_cmp++;
    if (n_fs != 2 || fs_at0 != 106 || fs_at1 - fs_at0 != 105) begin
      n_err++; $display("FAIL frame_period_b: got n=%0d at=%0d,%0d want 2 at 106,211", n_fs, fs_at0, fs_at1);
    end
  endtask

  initial begin
    test_reset();
    test_line_a();
    test_en_freeze_a();
    test_reset_mid_a();
    test_frame_b();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
